// File: rtl/pipeline_pkg.sv
// Shared pipeline types for the ID/EX stage.
// Datapath widths, ALU opcodes and the ID/EX register bundle.
package pipeline_pkg;

    localparam int WIDTH = 16;
    localparam int RA    = 3;
    localparam int OPW   = 3;

    typedef logic [WIDTH-1:0] word_t;
    typedef logic [RA-1:0]    reg_t;
    typedef logic [OPW-1:0]   op_t;

    localparam reg_t R0 = '0;

    typedef enum logic [OPW-1:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_ORR = 3'b011,
        ALU_XOR = 3'b100,
        ALU_NOT = 3'b101,
        ALU_MOV = 3'b110
    } aluop_e;

    typedef struct packed {
        logic  valid;
        op_t   aluop;
        reg_t  rs1;
        reg_t  rs2;
        reg_t  rd;
        logic  use_imm;
        word_t rs1_data;
        word_t rs2_data;
        word_t imm;
        logic  reg_write;
        logic  mem_read;
        logic  mem_write;
        logic  set_flags;
    } id_ex_t;

endpackage

// File: rtl/id_ex_stage_if.sv
// ID/EX stage bus: ID inputs, forward sources and EX outputs.
// master drives the ID side, slave is the stage itself.
interface id_ex_stage_if;
    import pipeline_pkg::*;

    logic  id_valid;
    op_t   id_aluop;
    reg_t  id_rs1;
    reg_t  id_rs2;
    reg_t  id_rd;
    logic  id_use_rs1;
    logic  id_use_rs2;
    word_t id_rs1_data;
    word_t id_rs2_data;
    word_t id_imm;
    logic  id_use_imm;
    logic  id_reg_write;
    logic  id_mem_read;
    logic  id_mem_write;
    logic  id_set_flags;
    logic  flush;
    logic  hold;
    logic  exmem_reg_write;
    reg_t  exmem_rd;
    word_t exmem_result;
    logic  memwb_reg_write;
    reg_t  memwb_rd;
    word_t memwb_result;
    logic  ex_valid;
    op_t   ex_aluop;
    word_t ex_operand1;
    word_t ex_operand2;
    word_t ex_store_data;
    reg_t  ex_rd;
    logic  ex_reg_write;
    logic  ex_mem_read;
    logic  ex_mem_write;
    logic  ex_set_flags;
    logic  stall_out;

    modport master (
        output id_valid, id_aluop, id_rs1, id_rs2, id_rd,
        output id_use_rs1, id_use_rs2, id_rs1_data, id_rs2_data,
        output id_imm, id_use_imm, id_reg_write, id_mem_read,
        output id_mem_write, id_set_flags, flush, hold,
        output exmem_reg_write, exmem_rd, exmem_result,
        output memwb_reg_write, memwb_rd, memwb_result,
        input  ex_valid, ex_aluop, ex_operand1, ex_operand2,
        input  ex_store_data, ex_rd, ex_reg_write, ex_mem_read,
        input  ex_mem_write, ex_set_flags, stall_out
    );

    modport slave (
        input  id_valid, id_aluop, id_rs1, id_rs2, id_rd,
        input  id_use_rs1, id_use_rs2, id_rs1_data, id_rs2_data,
        input  id_imm, id_use_imm, id_reg_write, id_mem_read,
        input  id_mem_write, id_set_flags, flush, hold,
        input  exmem_reg_write, exmem_rd, exmem_result,
        input  memwb_reg_write, memwb_rd, memwb_result,
        output ex_valid, ex_aluop, ex_operand1, ex_operand2,
        output ex_store_data, ex_rd, ex_reg_write, ex_mem_read,
        output ex_mem_write, ex_set_flags, stall_out
    );

endinterface

// File: rtl/id_ex_stage_fwd_unit.sv
// Per-source operand forward select.
// EX/MEM beats MEM/WB; r0 never forwards.
module fwd_unit
    import pipeline_pkg::*;
(
    input  reg_t  i_rs,
    input  word_t i_stored,
    input  logic  i_exmem_we,
    input  reg_t  i_exmem_rd,
    input  word_t i_exmem_res,
    input  logic  i_memwb_we,
    input  reg_t  i_memwb_rd,
    input  word_t i_memwb_res,
    output word_t o_data
);

    logic w_nz;

    assign w_nz = (i_rs != R0);

    // pick the youngest in-flight producer of i_rs
    always_comb begin
        o_data = i_stored;
        if (w_nz && i_exmem_we && i_exmem_rd == i_rs)
            o_data = i_exmem_res;
        else if (w_nz && i_memwb_we && i_memwb_rd == i_rs)
            o_data = i_memwb_res;
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with forwarding and load-use detection.
// Feeds the ALU operands/op and the EX/MEM control bits.
module id_ex_stage
    import pipeline_pkg::*;
(
    input logic         clk,
    input logic         rst_n,
    id_ex_stage_if.slave bus
);

    id_ex_t r_ex;
    id_ex_t w_id;
    word_t  w_fwd1;
    word_t  w_fwd2;
    logic   w_hit1;
    logic   w_hit2;
    logic   w_load_use;

    fwd_unit u_fwd_rs1 (
        .i_rs        (r_ex.rs1),
        .i_stored    (r_ex.rs1_data),
        .i_exmem_we  (bus.exmem_reg_write),
        .i_exmem_rd  (bus.exmem_rd),
        .i_exmem_res (bus.exmem_result),
        .i_memwb_we  (bus.memwb_reg_write),
        .i_memwb_rd  (bus.memwb_rd),
        .i_memwb_res (bus.memwb_result),
        .o_data      (w_fwd1)
    );

    fwd_unit u_fwd_rs2 (
        .i_rs        (r_ex.rs2),
        .i_stored    (r_ex.rs2_data),
        .i_exmem_we  (bus.exmem_reg_write),
        .i_exmem_rd  (bus.exmem_rd),
        .i_exmem_res (bus.exmem_result),
        .i_memwb_we  (bus.memwb_reg_write),
        .i_memwb_rd  (bus.memwb_rd),
        .i_memwb_res (bus.memwb_result),
        .o_data      (w_fwd2)
    );

    // load in EX whose result the ID instruction needs right now
    always_comb begin
        w_hit1 = bus.id_use_rs1 && (bus.id_rs1 == r_ex.rd);
        w_hit2 = bus.id_use_rs2 && (bus.id_rs2 == r_ex.rd);
        w_load_use = r_ex.valid && r_ex.mem_read
                  && (r_ex.rd != R0) && bus.id_valid
                  && (w_hit1 || w_hit2);
    end

    // bundle ID fields; controls of a non-instruction are dropped
    always_comb begin
        w_id           = '0;
        w_id.valid     = bus.id_valid;
        w_id.aluop     = bus.id_aluop;
        w_id.rs1       = bus.id_rs1;
        w_id.rs2       = bus.id_rs2;
        w_id.rd        = bus.id_rd;
        w_id.use_imm   = bus.id_use_imm;
        w_id.rs1_data  = bus.id_rs1_data;
        w_id.rs2_data  = bus.id_rs2_data;
        w_id.imm       = bus.id_imm;
        w_id.reg_write = bus.id_reg_write & bus.id_valid;
        w_id.mem_read  = bus.id_mem_read  & bus.id_valid;
        w_id.mem_write = bus.id_mem_write & bus.id_valid;
        w_id.set_flags = bus.id_set_flags & bus.id_valid;
    end

    // pipeline register: hold refreshes data, flush/hazard bubble
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex <= '0;
        end else if (bus.hold) begin
            r_ex.rs1_data <= w_fwd1;
            r_ex.rs2_data <= w_fwd2;
        end else if (bus.flush || w_load_use) begin
            r_ex.valid     <= 1'b0;
            r_ex.reg_write <= 1'b0;
            r_ex.mem_read  <= 1'b0;
            r_ex.mem_write <= 1'b0;
            r_ex.set_flags <= 1'b0;
        end else begin
            r_ex <= w_id;
        end
    end

    assign bus.ex_valid      = r_ex.valid;
    assign bus.ex_aluop      = r_ex.aluop;
    assign bus.ex_rd         = r_ex.rd;
    assign bus.ex_operand1   = w_fwd1;
    assign bus.ex_operand2   = r_ex.use_imm ? r_ex.imm : w_fwd2;
    assign bus.ex_store_data = w_fwd2;
    assign bus.ex_reg_write  = r_ex.valid & r_ex.reg_write;
    assign bus.ex_mem_read   = r_ex.valid & r_ex.mem_read;
    assign bus.ex_mem_write  = r_ex.valid & r_ex.mem_write;
    assign bus.ex_set_flags  = r_ex.valid & r_ex.set_flags;
    assign bus.stall_out     = bus.hold | (w_load_use & ~bus.flush);

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed scenarios plus random traffic
// compared against a behavioural model of the EX slot.
module tb_id_ex_stage;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    id_ex_stage_if bus ();

    id_ex_stage dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic [2:0]  op;
        logic [2:0]  rs1;
        logic [2:0]  rs2;
        logic [2:0]  rd;
        logic        use_imm;
        logic [15:0] d1;
        logic [15:0] d2;
        logic [15:0] imm;
        logic        rw;
        logic        mr;
        logic        mw;
        logic        sf;
    } slot_t;

    slot_t m;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] fwd(input logic [2:0] rs,
                                        input logic [15:0] stored);
        if (rs == 0) return stored;
        if (bus.exmem_reg_write && bus.exmem_rd == rs)
            return bus.exmem_result;
        if (bus.memwb_reg_write && bus.memwb_rd == rs)
            return bus.memwb_result;
        return stored;
    endfunction

    function automatic logic hazard();
        logic need;
        need = (bus.id_use_rs1 && bus.id_rs1 == m.rd)
            || (bus.id_use_rs2 && bus.id_rs2 == m.rd);
        return m.valid && m.mr && m.rd != 0 && bus.id_valid && need;
    endfunction

    task automatic clear_model();
        m = '{default: '0};
    endtask

    task automatic cmp_all(input string tag);
        logic [15:0] e2;
        logic        es;
        e2 = m.use_imm ? m.imm : fwd(m.rs2, m.d2);
        es = bus.hold || (hazard() && !bus.flush);
        chk({tag, ".valid"}, bus.ex_valid, m.valid);
        chk({tag, ".op"}, bus.ex_aluop, m.op);
        chk({tag, ".rd"}, bus.ex_rd, m.rd);
        chk({tag, ".op1"}, bus.ex_operand1, fwd(m.rs1, m.d1));
        chk({tag, ".op2"}, bus.ex_operand2, e2);
        chk({tag, ".sd"}, bus.ex_store_data, fwd(m.rs2, m.d2));
        chk({tag, ".rw"}, bus.ex_reg_write, m.valid && m.rw);
        chk({tag, ".mr"}, bus.ex_mem_read, m.valid && m.mr);
        chk({tag, ".mw"}, bus.ex_mem_write, m.valid && m.mw);
        chk({tag, ".sf"}, bus.ex_set_flags, m.valid && m.sf);
        chk({tag, ".stall"}, bus.stall_out, es);
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst_n) begin
            clear_model();
        end else if (bus.hold) begin
            m.d1 = fwd(m.rs1, m.d1);
            m.d2 = fwd(m.rs2, m.d2);
        end else if (bus.flush || hazard()) begin
            m.valid = 0;
            m.rw = 0;
            m.mr = 0;
            m.mw = 0;
            m.sf = 0;
        end else begin
            m.valid   = bus.id_valid;
            m.op      = bus.id_aluop;
            m.rs1     = bus.id_rs1;
            m.rs2     = bus.id_rs2;
            m.rd      = bus.id_rd;
            m.use_imm = bus.id_use_imm;
            m.d1      = bus.id_rs1_data;
            m.d2      = bus.id_rs2_data;
            m.imm     = bus.id_imm;
            m.rw      = bus.id_valid && bus.id_reg_write;
            m.mr      = bus.id_valid && bus.id_mem_read;
            m.mw      = bus.id_valid && bus.id_mem_write;
            m.sf      = bus.id_valid && bus.id_set_flags;
        end
        @(negedge clk);
    endtask

    task automatic idle();
        bus.id_valid        = 0;
        bus.id_aluop        = 0;
        bus.id_rs1          = 0;
        bus.id_rs2          = 0;
        bus.id_rd           = 0;
        bus.id_use_rs1      = 0;
        bus.id_use_rs2      = 0;
        bus.id_rs1_data     = 0;
        bus.id_rs2_data     = 0;
        bus.id_imm          = 0;
        bus.id_use_imm      = 0;
        bus.id_reg_write    = 0;
        bus.id_mem_read     = 0;
        bus.id_mem_write    = 0;
        bus.id_set_flags    = 0;
        bus.flush           = 0;
        bus.hold            = 0;
        bus.exmem_reg_write = 0;
        bus.exmem_rd        = 0;
        bus.exmem_result    = 0;
        bus.memwb_reg_write = 0;
        bus.memwb_rd        = 0;
        bus.memwb_result    = 0;
    endtask

    task automatic issue(input logic [2:0] op, input logic [2:0] rs1,
                         input logic [15:0] d1, input logic [2:0] rs2,
                         input logic [15:0] d2, input logic [2:0] rd,
                         input logic mr);
        bus.id_valid     = 1;
        bus.id_aluop     = op;
        bus.id_rs1       = rs1;
        bus.id_rs2       = rs2;
        bus.id_rd        = rd;
        bus.id_use_rs1   = 1;
        bus.id_use_rs2   = !mr;
        bus.id_rs1_data  = d1;
        bus.id_rs2_data  = d2;
        bus.id_use_imm   = 0;
        bus.id_imm       = 0;
        bus.id_reg_write = 1;
        bus.id_mem_read  = mr;
    endtask

    task automatic randomize_inputs();
        bus.id_valid        = ($urandom % 4) != 0;
        bus.id_aluop        = 3'($urandom_range(0, 6));
        bus.id_rs1          = 3'($urandom_range(0, 4));
        bus.id_rs2          = 3'($urandom_range(0, 4));
        bus.id_rd           = 3'($urandom_range(0, 4));
        bus.id_use_rs1      = 1'($urandom);
        bus.id_use_rs2      = 1'($urandom);
        bus.id_rs1_data     = 16'($urandom);
        bus.id_rs2_data     = 16'($urandom);
        bus.id_imm          = 16'($urandom);
        bus.id_use_imm      = 1'($urandom);
        bus.id_reg_write    = 1'($urandom);
        bus.id_mem_read     = ($urandom % 3) == 0;
        bus.id_mem_write    = 1'($urandom);
        bus.id_set_flags    = 1'($urandom);
        bus.flush           = ($urandom % 8) == 0;
        bus.hold            = ($urandom % 6) == 0;
        bus.exmem_reg_write = 1'($urandom);
        bus.exmem_rd        = 3'($urandom_range(0, 4));
        bus.exmem_result    = 16'($urandom);
        bus.memwb_reg_write = 1'($urandom);
        bus.memwb_rd        = 3'($urandom_range(0, 4));
        bus.memwb_result    = 16'($urandom);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 0;
        idle();
        clear_model();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1;

        // mid-run reset clears a live instruction
        issue(3'd3, 3'd1, 16'h1111, 3'd2, 16'h2222, 3'd6, 1'b1);
        tick();
        idle();
        rst_n = 0;
        clear_model();
        #1;
        chk("rst.valid", bus.ex_valid, 1'b0);
        chk("rst.op1", bus.ex_operand1, 16'h0);
        chk("rst.mr", bus.ex_mem_read, 1'b0);
        chk("rst.stall", bus.stall_out, 1'b0);
        tick();
        rst_n = 1;

        // plain capture of ADD r1=5, r2=7
        issue(3'd0, 3'd1, 16'd5, 3'd2, 16'd7, 3'd3, 1'b0);
        tick();
        idle();
        #1;
        chk("cap.op", bus.ex_aluop, 3'd0);
        chk("cap.op1", bus.ex_operand1, 16'd5);
        chk("cap.op2", bus.ex_operand2, 16'd7);
        chk("cap.valid", bus.ex_valid, 1'b1);

        // forward priority on rs1=r3
        issue(3'd0, 3'd3, 16'h0011, 3'd0, 16'h0, 3'd1, 1'b0);
        tick();
        idle();
        bus.exmem_reg_write = 1;
        bus.exmem_rd        = 3'd3;
        bus.exmem_result    = 16'h00AA;
        bus.memwb_reg_write = 1;
        bus.memwb_rd        = 3'd3;
        bus.memwb_result    = 16'h0055;
        #1;
        chk("fwd.exmem", bus.ex_operand1, 16'h00AA);
        bus.exmem_reg_write = 0;
        #1;
        chk("fwd.memwb", bus.ex_operand1, 16'h0055);
        bus.memwb_reg_write = 0;
        #1;
        chk("fwd.stored", bus.ex_operand1, 16'h0011);
        tick();

        // load-use: one bubble, then SUB enters EX
        issue(3'd0, 3'd1, 16'h0, 3'd0, 16'h0, 3'd4, 1'b1);
        tick();
        issue(3'd1, 3'd4, 16'h0, 3'd2, 16'h0, 3'd5, 1'b0);
        #1;
        chk("lu.stall", bus.stall_out, 1'b1);
        tick();
        #1;
        chk("lu.bub.valid", bus.ex_valid, 1'b0);
        chk("lu.bub.rw", bus.ex_reg_write, 1'b0);
        chk("lu.bub.stall", bus.stall_out, 1'b0);
        tick();
        idle();
        #1;
        chk("lu.sub.valid", bus.ex_valid, 1'b1);
        chk("lu.sub.op", bus.ex_aluop, 3'd1);
        chk("lu.sub.rd", bus.ex_rd, 3'd5);

        // flush overrides the hazard
        issue(3'd0, 3'd1, 16'h0, 3'd0, 16'h0, 3'd4, 1'b1);
        tick();
        issue(3'd1, 3'd4, 16'h0, 3'd2, 16'h0, 3'd5, 1'b0);
        bus.flush = 1;
        #1;
        chk("fl.stall", bus.stall_out, 1'b0);
        tick();
        idle();
        #1;
        chk("fl.valid", bus.ex_valid, 1'b0);
        chk("fl.rw", bus.ex_reg_write, 1'b0);

        // hold keeps a forward that retires mid-hold
        issue(3'd2, 3'd1, 16'h0001, 3'd2, 16'h0000, 3'd7, 1'b0);
        tick();
        issue(3'd4, 3'd5, 16'h0, 3'd6, 16'h0, 3'd3, 1'b0);
        bus.hold            = 1;
        bus.memwb_reg_write = 1;
        bus.memwb_rd        = 3'd2;
        bus.memwb_result    = 16'h1234;
        #1;
        chk("hold.op2.0", bus.ex_operand2, 16'h1234);
        chk("hold.stall", bus.stall_out, 1'b1);
        for (int k = 1; k < 3; k++) begin
            tick();
            bus.memwb_reg_write = 0;
            #1;
            chk("hold.op2", bus.ex_operand2, 16'h1234);
            chk("hold.sd", bus.ex_store_data, 16'h1234);
            chk("hold.op", bus.ex_aluop, 3'd2);
            chk("hold.rd", bus.ex_rd, 3'd7);
            chk("hold.valid", bus.ex_valid, 1'b1);
        end
        tick();
        idle();

        // r0 never forwards; immediate replaces operand2 only
        issue(3'd0, 3'd0, 16'h0000, 3'd6, 16'h0042, 3'd1, 1'b0);
        bus.id_use_imm = 1;
        bus.id_imm     = 16'hFFF0;
        tick();
        idle();
        bus.exmem_reg_write = 1;
        bus.exmem_rd        = 3'd0;
        bus.exmem_result    = 16'hFFFF;
        #1;
        chk("r0.op1", bus.ex_operand1, 16'h0000);
        chk("imm.op2", bus.ex_operand2, 16'hFFF0);
        chk("imm.sd", bus.ex_store_data, 16'h0042);
        bus.exmem_rd     = 3'd6;
        bus.exmem_result = 16'h7777;
        #1;
        chk("imm.op2.f", bus.ex_operand2, 16'hFFF0);
        chk("imm.sd.f", bus.ex_store_data, 16'h7777);
        tick();

        // random traffic against the model
        for (int i = 0; i < 500; i++) begin
            randomize_inputs();
            if (($urandom % 60) == 0) begin
                rst_n = 0;
                clear_model();
            end else begin
                rst_n = 1;
            end
            #1;
            cmp_all("rnd");
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
